dmem_responder: RTL



---
 rtl/dmem_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per request, fixed access latency, extended load data.
// Latency MEM_DELAY+1 cycles of stall, then a one-cycle DONE with rvalid/err; stall backpressures the pipeline.
module dmem_responder #(
    parameter int DEPTH_LOG = 10,
    parameter int MEM_DELAY = 3
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        dram_re,
    input  logic        dram_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        err,
    output logic        stall
);

    localparam int         WORDS    = 1 << DEPTH_LOG;
    localparam logic [3:0] CNT_LAST = 4'(MEM_DELAY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [DEPTH_LOG-1:0]   idx_q;
    logic [1:0]             lane_q;
    logic [2:0]             funct3_q;
    logic [31:0]            wdata_q;
    logic                   store_q;
    logic [31:0]            rdata_q;
    logic                   rvalid_q;
    logic                   err_q;

    logic                   accept;
    logic                   finish;
    logic                   legal;
    logic [3:0]             be;
    logic [31:0]            wd;
    logic [31:0]            rd_word;
    logic [31:0]            rd_byte_sh;
    logic [31:0]            rd_half_sh;
    logic [31:0]            load_ext;
    logic                   unused_addr_hi;

    logic [31:0] mem [WORDS];

    assign unused_addr_hi = ^addr[31:DEPTH_LOG+2];

    assign accept = (state_q == IDLE) && (dram_re || dram_we);
    assign finish = (state_q == WAIT) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = WAIT;
                    cnt_d   = 4'd0;
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Loads accept only the unsigned variants 100/101 on top of the shared sizes.
    always_comb begin
        legal = 1'b0;
        case (funct3_q)
            3'b000:          legal = 1'b1;
            3'b001:          legal = ~lane_q[0];
            3'b010:          legal = (lane_q == 2'b00);
            3'b100, 3'b101:  legal = ~store_q;
            default:         legal = 1'b0;
        endcase
    end

    always_comb begin
        be = 4'b0000;
        wd = 32'd0;
        case (funct3_q)
            3'b000: begin
                be = 4'b0001 << lane_q;
                wd = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                be = 4'b0011 << {lane_q[1], 1'b0};
                wd = {2{wdata_q[15:0]}};
            end
            3'b010: begin
                be = 4'b1111;
                wd = wdata_q;
            end
            default: begin
                be = 4'b0000;
                wd = 32'd0;
            end
        endcase
    end

    assign rd_word    = mem[idx_q];
    assign rd_byte_sh = rd_word >> {lane_q, 3'b000};
    assign rd_half_sh = rd_word >> {lane_q[1], 4'b0000};

    always_comb begin
        load_ext = 32'd0;
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
            3'b001:  load_ext = {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
            3'b010:  load_ext = rd_word;
            3'b100:  load_ext = {24'd0, rd_byte_sh[7:0]};
            3'b101:  load_ext = {16'd0, rd_half_sh[15:0]};
            default: load_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= finish && legal && !store_q;
            err_q    <= finish && !legal;
            if (finish && !store_q) begin
                rdata_q <= legal ? load_ext : 32'd0;
            end
        end
    end

    // Request fields are captured once at acceptance; a simultaneous re/we is treated as a store.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q    <= addr[DEPTH_LOG+1:2];
            lane_q   <= addr[1:0];
            funct3_q <= funct3;
            wdata_q  <= wdata;
            store_q  <= dram_we;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst && finish && legal && store_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx_q][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule
